// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and
// line/frame constants.
package fifo_uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and can be cleared.
// tick_o marks the last clock of a bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream synchronous FIFO
// (one-cycle read latency) and serialises them LSB first.
//
//   state | meaning
//   IDLE  | line high, waiting for a non-empty FIFO
//   FETCH | one-cycle FIFO pop request
//   LOAD  | capture FIFO read data into the shift register
//   START | start bit (line low), one bit period
//   DATA  | eight data bits, LSB first, one bit period each
//   STOP  | stop bit (line high); done pulses on its last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_rd_en_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic [IW-1:0]          bit_idx_q;
  logic [IW-1:0]          bit_idx_d;
  logic                   tx_q;
  logic                   tx_d;
  logic                   baud_tick;
  logic                   baud_clr;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE:  if (!fifo_empty_i) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data_i;
        state_d = START;
      end
      START: if (baud_tick) state_d = DATA;
      DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP:  if (baud_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the next state so tx_o never glitches.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign baud_clr = (state_d != state_q);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (baud_clr),
    .tick_o(baud_tick)
  );

  assign fifo_rd_en_o = (state_q == FETCH);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == STOP) && baud_tick;
  assign tx_o         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at 4 and 2 clocks per bit, each fed by a queue-style
// FIFO model; frames are decoded from the line and compared with sent bytes.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tx4, busy4, rd_en4, done4;
  logic       tx2, busy2, rd_en2, done2;
  logic [7:0] data4 = '0;
  logic [7:0] data2 = '0;
  logic [7:0] mem4 [16];
  logic [7:0] mem2 [16];
  int         wr4 = 0, rd4 = 0, wr2 = 0, rd2 = 0;
  logic       empty4, empty2;
  int         rdc4 = 0, dnc4 = 0, rdc2 = 0, dnc2 = 0, under4 = 0, under2 = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  assign empty4 = (wr4 == rd4);
  assign empty2 = (wr2 == rd2);

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty_i(empty4), .fifo_data_i(data4),
    .fifo_rd_en_o(rd_en4), .tx_o(tx4), .busy_o(busy4), .done_o(done4)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty_i(empty2), .fifo_data_i(data2),
    .fifo_rd_en_o(rd_en2), .tx_o(tx2), .busy_o(busy2), .done_o(done2)
  );

  // Upstream FIFO models: read data valid one clock after a pop cycle.
  always @(posedge clk) begin
    if (rd_en4) begin
      rdc4 <= rdc4 + 1;
      if (empty4) under4 <= under4 + 1;
      else begin
        data4 <= mem4[rd4 % 16];
        rd4   <= rd4 + 1;
      end
    end
    if (rd_en2) begin
      rdc2 <= rdc2 + 1;
      if (empty2) under2 <= under2 + 1;
      else begin
        data2 <= mem2[rd2 % 16];
        rd2   <= rd2 + 1;
      end
    end
    if (done4) dnc4 <= dnc4 + 1;
    if (done2) dnc2 <= dnc2 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic txs(input int n);
    return (n == 4) ? tx4 : tx2;
  endfunction
  function automatic logic bss(input int n);
    return (n == 4) ? busy4 : busy2;
  endfunction
  function automatic logic dns(input int n);
    return (n == 4) ? done4 : done2;
  endfunction

  task automatic push(input int n, input logic [7:0] b);
    if (n == 4) begin mem4[wr4 % 16] = b; wr4 = wr4 + 1; end
    else        begin mem2[wr2 % 16] = b; wr2 = wr2 + 1; end
  endtask

  // Negedges until the line is seen low; -1 if the budget expires.
  task automatic wait_fall(input int n, input int budget, output int w);
    w = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (txs(n) == 1'b0) begin
        w = i;
        break;
      end
    end
  endtask

  // Record one frame starting at the current negedge (first start-bit cycle).
  task automatic grab_frame(input int n, output logic [9:0] bits, output logic shape_ok,
                            output logic busy_ok, output int done_at, output int done_n);
    shape_ok = 1'b1; busy_ok = 1'b1; done_at = -1; done_n = 0; bits = '0;
    for (int k = 0; k < 10 * n; k++) begin
      if (k > 0) @(negedge clk);
      if (k % n == 0) bits[k / n] = txs(n);
      else if (txs(n) !== bits[k / n]) shape_ok = 1'b0;
      if (dns(n)) begin done_n++; done_at = k; end
      if (!bss(n)) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if ({tx4, busy4, rd_en4, done4} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_dut4: tx,busy,rd,done=%b required 1000", {tx4, busy4, rd_en4, done4});
    end
    n_checks++; if ({tx2, busy2, rd_en2, done2} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_dut2: tx,busy,rd,done=%b required 1000", {tx2, busy2, rd_en2, done2});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({tx4, busy4, tx2, busy2} !== 4'b1010) begin
      n_fail++; $display("FAIL idle_after_reset: tx4,busy4,tx2,busy2=%b required 1010", {tx4, busy4, tx2, busy2});
    end
  endtask

  task automatic test_single_byte;
    logic [9:0] bits; logic shape_ok, busy_ok; int w, done_at, done_n, rd0, dn0;
    logic [7:0] b = 8'hA5;
    rd0 = rdc4; dn0 = dnc4;
    push(4, b);
    wait_fall(4, 12, w);
    n_checks++; if (w != 3) begin n_fail++; $display("FAIL single_latency: got %0d required 3", w); end
    grab_frame(4, bits, shape_ok, busy_ok, done_at, done_n);
    n_checks++; if (bits !== {1'b1, b, 1'b0}) begin
      n_fail++; $display("FAIL single_bits: got %b required %b (LSB first)", bits, {1'b1, b, 1'b0});
    end
    n_checks++; if (!shape_ok || !busy_ok) begin
      n_fail++; $display("FAIL single_shape: bit_stable=%b busy_held=%b required 1 1", shape_ok, busy_ok);
    end
    n_checks++; if (done_n != 1 || done_at != 39) begin
      n_fail++; $display("FAIL single_done: %0d pulses at cycle %0d required 1 at 39", done_n, done_at);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (rdc4 - rd0 != 1 || dnc4 - dn0 != 1 || busy4 !== 1'b0 || tx4 !== 1'b1) begin
      n_fail++; $display("FAIL single_counts: rd=%0d done=%0d busy=%b tx=%b required 1 1 0 1",
                         rdc4 - rd0, dnc4 - dn0, busy4, tx4);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits; logic shape_ok, busy_ok; int w, done_at, done_n, rd0;
    logic [7:0] exp [2];
    exp[0] = 8'h00; exp[1] = 8'hFF;
    rd0 = rdc4;
    push(4, exp[0]); push(4, exp[1]);
    wait_fall(4, 12, w);
    n_checks++; if (w != 3) begin n_fail++; $display("FAIL b2b_latency: got %0d required 3", w); end
    for (int i = 0; i < 2; i++) begin
      grab_frame(4, bits, shape_ok, busy_ok, done_at, done_n);
      n_checks++; if (bits !== {1'b1, exp[i], 1'b0} || !shape_ok || done_at != 39) begin
        n_fail++; $display("FAIL b2b_frame%0d: bits=%b stable=%b done_at=%0d required %b 1 39",
                           i, bits, shape_ok, done_at, {1'b1, exp[i], 1'b0});
      end
      if (i == 0) begin
        wait_fall(4, 12, w);
        n_checks++; if (w - 1 != 3) begin
          n_fail++; $display("FAIL b2b_gap: got %0d idle-high cycles required 3", w - 1);
        end
      end
    end
    repeat (6) @(negedge clk);
    n_checks++; if (rdc4 - rd0 != 2 || empty4 !== 1'b1 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: rd=%0d empty=%b busy=%b required 2 1 0", rdc4 - rd0, empty4, busy4);
    end
  endtask

  task automatic test_empty_fifo;
    int bad_rd = 0, bad_tx = 0, bad_busy = 0, u0;
    u0 = under4 + under2;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_en4 || rd_en2) bad_rd++;
      if (tx4 !== 1'b1 || tx2 !== 1'b1) bad_tx++;
      if (busy4 || busy2) bad_busy++;
    end
    n_checks++; if (bad_rd != 0 || under4 + under2 != u0) begin
      n_fail++; $display("FAIL empty_no_pop: rd_en high %0d cycles, underflows %0d required 0 0",
                         bad_rd, under4 + under2 - u0);
    end
    n_checks++; if (bad_tx != 0 || bad_busy != 0) begin
      n_fail++; $display("FAIL empty_idle: tx low %0d, busy high %0d cycles required 0 0", bad_tx, bad_busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] bits; logic shape_ok, busy_ok; int w, done_at, done_n, rd0, dn0;
    logic [7:0] b0 = 8'h3C;
    logic [7:0] b1 = 8'h5A;
    rd0 = rdc4; dn0 = dnc4;
    push(4, b0); push(4, b1);
    wait_fall(4, 12, w);
    n_checks++; if (w != 3) begin n_fail++; $display("FAIL rstmid_latency: got %0d required 3", w); end
    repeat (17) @(negedge clk);
    n_checks++; if (tx4 !== b0[3] || busy4 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_bit3: tx=%b busy=%b required %b 1", tx4, busy4, b0[3]);
    end
    rst = 1'b1;
    #1;
    n_checks++; if ({tx4, busy4, rd_en4, done4} !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_immediate: tx,busy,rd,done=%b required 1000", {tx4, busy4, rd_en4, done4});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fall(4, 12, w);
    n_checks++; if (w != 3) begin n_fail++; $display("FAIL rstmid_resume: got %0d required 3", w); end
    grab_frame(4, bits, shape_ok, busy_ok, done_at, done_n);
    n_checks++; if (bits !== {1'b1, b1, 1'b0} || !shape_ok || done_at != 39) begin
      n_fail++; $display("FAIL rstmid_next: bits=%b stable=%b done_at=%0d required %b 1 39",
                         bits, shape_ok, done_at, {1'b1, b1, 1'b0});
    end
    repeat (4) @(negedge clk);
    n_checks++; if (dnc4 - dn0 != 1 || rdc4 - rd0 != 2 || empty4 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_counts: done=%0d rd=%0d empty=%b required 1 2 1",
                         dnc4 - dn0, rdc4 - rd0, empty4);
    end
  endtask

  task automatic test_boundary_rate;
    logic [9:0] bits; logic shape_ok, busy_ok; int w, done_at, done_n, rd0, dn0;
    int bad_data = 0, bad_len = 0;
    rd0 = rdc2; dn0 = dnc2;
    for (int i = 1; i <= 8; i++) push(2, 8'(i));
    wait_fall(2, 12, w);
    n_checks++; if (w != 3) begin n_fail++; $display("FAIL rate2_latency: got %0d required 3", w); end
    for (int i = 0; i < 8; i++) begin
      grab_frame(2, bits, shape_ok, busy_ok, done_at, done_n);
      if (bits !== {1'b1, 8'(i + 1), 1'b0}) bad_data++;
      if (!shape_ok || !busy_ok || done_n != 1 || done_at != 19) bad_len++;
      if (i < 7) begin
        wait_fall(2, 12, w);
        if (w != 4) bad_len++;
      end
    end
    n_checks++; if (bad_data != 0) begin
      n_fail++; $display("FAIL rate2_data: %0d frames wrong required 0", bad_data);
    end
    n_checks++; if (bad_len != 0) begin
      n_fail++; $display("FAIL rate2_timing: %0d frame/gap timing errors required 0", bad_len);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (dnc2 - dn0 != 8 || rdc2 - rd0 != 8 || empty2 !== 1'b1) begin
      n_fail++; $display("FAIL rate2_counts: done=%0d rd=%0d empty=%b required 8 8 1",
                         dnc2 - dn0, rdc2 - rd0, empty2);
    end
  endtask

  task automatic test_random;
    logic [9:0] bits; logic shape_ok, busy_ok; int w, done_at, done_n, dn0, burst;
    logic [7:0] expq [$];
    logic [7:0] b, e;
    dn0 = dnc4;
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      burst = $urandom_range(1, 3);
      for (int j = 0; j < burst; j++) begin
        b = 8'($urandom_range(0, 255));
        push(4, b);
        expq.push_back(b);
      end
      for (int j = 0; j < burst; j++) begin
        wait_fall(4, 12, w);
        n_checks++; if (w != ((j == 0) ? 3 : 4)) begin
          n_fail++; $display("FAIL rand_gap: burst %0d byte %0d waited %0d required %0d", r, j, w, (j == 0) ? 3 : 4);
        end
        grab_frame(4, bits, shape_ok, busy_ok, done_at, done_n);
        e = expq.pop_front();
        n_checks++; if (bits !== {1'b1, e, 1'b0} || !shape_ok || !busy_ok || done_at != 39) begin
          n_fail++; $display("FAIL rand_frame: bits=%b stable=%b busy=%b done_at=%0d required %b 1 1 39",
                             bits, shape_ok, busy_ok, done_at, {1'b1, e, 1'b0});
        end
      end
    end
    repeat (4) @(negedge clk);
    n_checks++; if (under4 != 0 || empty4 !== 1'b1 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL rand_end: underflows=%0d empty=%b busy=%b required 0 1 0", under4, empty4, busy4);
    end
    if (dnc4 - dn0 < 5) begin
      n_checks++; n_fail++; $display("FAIL rand_done_count: %0d required at least 5", dnc4 - dn0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_fifo();
    test_reset_mid_frame();
    test_boundary_rate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fifo_empty_i  input  1  empty flag from the upstream synchronous FIFO.
REQ-005 SHALL have port fifo_data_i  input  8  FIFO read data, valid one clock after a read-enable cycle.
REQ-006 SHALL have port fifo_rd_en_o  output  1  FIFO pop request, one-cycle pulse per byte.
REQ-007 SHALL have port tx_o  output  1  serial line, 8N1, idle high.
REQ-008 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse when a byte's stop bit completes.

Function
REQ-010 SHALL implement Moore FSM with states IDLE, FETCH, LOAD, START, DATA, STOP; all outputs registered or decoded from state only.
REQ-011 SHALL, in IDLE with fifo_empty_i=0 at a rising edge, move to FETCH; with fifo_empty_i=1, stay in IDLE.
REQ-012 SHALL drive fifo_rd_en_o=1 only in FETCH, which lasts exactly one cycle, then move to LOAD.
REQ-013 SHALL, in LOAD (one cycle), capture fifo_data_i into an 8-bit shift register, then move to START.
REQ-014 SHALL hold tx_o=0 in START for CLKS_PER_BIT cycles; tx_o falls at the 3rd rising edge after the IDLE edge that sampled fifo_empty_i=0.
REQ-015 SHALL in DATA send 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index wrapping 7->0 on exit.
REQ-016 SHALL hold tx_o=1 in STOP for CLKS_PER_BIT cycles, pulse done_o on STOP's final cycle, then return to IDLE.
REQ-017 SHALL produce a frame of exactly 10*CLKS_PER_BIT cycles from tx_o falling to STOP exit; back-to-back bytes add 3 cycles (IDLE, FETCH, LOAD) of gap with tx_o=1.
REQ-018 SHALL use a baud counter of width clog2(CLKS_PER_BIT), cleared on every state entry, terminal at CLKS_PER_BIT-1.
REQ-019 SHALL ignore fifo_empty_i and fifo_data_i outside IDLE and LOAD respectively; empty rising mid-frame has no effect.
REQ-020 SHALL never assert fifo_rd_en_o in a cycle following an IDLE sample of fifo_empty_i=1 (no underflow pop).
REQ-021 SHALL keep tx_o=1 and busy_o=0 in IDLE.

Reset
REQ-022 SHALL, on rst=1, immediately force state IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, done_o=0, counters and shift register to 0.
REQ-023 SHALL, on reset asserted mid-frame, abandon the byte (no done_o, no re-pop) and resume from IDLE at the first edge after rst falls.

Structure
REQ-024 SHALL place the FSM state enum, DATA_BITS=8, and LINE_IDLE=1 in shared package fifo_uart_pkg.
REQ-025 SHALL instantiate one sub-module uart_baud_cnt (clear input, tick output at CLKS_PER_BIT-1); all else in fifo_uart_tx.

Verification
REQ-026 SHALL cover single byte: CLKS_PER_BIT=4, FIFO holds 0xA5 -> tx_o bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; one rd_en pulse; one done_o.
REQ-027 SHALL cover back-to-back: FIFO holds 0x00,0xFF -> two frames separated by exactly 3 idle-high cycles; two rd_en pulses; FIFO ends empty.
REQ-028 SHALL cover empty FIFO: fifo_empty_i=1 for 200 cycles -> fifo_rd_en_o never high, tx_o=1, busy_o=0.
REQ-029 SHALL cover reset mid-frame: rst pulsed during DATA bit 3 of 0x3C -> tx_o=1 same cycle, no done_o, next byte popped cleanly after release.
REQ-030 SHALL cover boundary rate: CLKS_PER_BIT=2, 8-deep FIFO filled with 0x01..0x08 -> eight frames of 20 cycles, data matches in order, done_o count 8.
